// File: rtl/dm_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int BE_W   = 4;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] ABORT_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CPU_BUSY = 2'd1,
    ST_DMA_BUSY = 2'd2
  } state_t;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester and memory-side signal bundle; slave = arbiter, master = environment.
interface dm_arbiter_if;
  import dm_arbiter_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [BE_W-1:0]   cpu_be;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [BE_W-1:0]   dma_be;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_be, dma_wdata,
    output dma_gnt, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ready,
    output err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_be, dma_wdata,
    input  dma_gnt, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ready,
    input  err
  );

endinterface

// File: rtl/dm_arbiter_rr_pick2.sv
// Two-requester round-robin picker: index 0 = CPU, 1 = DMA.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last_owner,
  output logic       o_gnt_idx,
  output logic       o_any
);

  always_comb begin
    o_any     = |i_req;
    o_gnt_idx = i_req[1];
    // On a tie the requester that did not own the memory last goes first.
    if (i_req == 2'b11) o_gnt_idx = ~i_last_owner;
  end

endmodule

// File: rtl/dm_arbiter.sv
// Single-port data memory arbiter between the CPU MEM stage and a DMA port,
// with registered memory-side outputs and a ready-handshake watchdog.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input logic         clk,
  input logic         reset,
  dm_arbiter_if.slave bus
);

  state_t            r_state, w_next;
  logic              r_last_owner;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mem_en, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [BE_W-1:0]   r_mem_be;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;

  logic [1:0] w_pick_req;
  logic       w_gnt_idx, w_any;
  logic       w_busy, w_done, w_timeout, w_end;

  assign w_busy    = (r_state != ST_IDLE);
  assign w_done    = w_busy & bus.mem_ready;
  assign w_timeout = w_busy & ~bus.mem_ready & (r_cnt == CNT_W'(TIMEOUT));
  assign w_end     = w_done | w_timeout;

  // The completing owner is masked: its request line already belongs to the next access.
  always_comb begin
    w_pick_req = 2'b00;
    case (r_state)
      ST_IDLE:     w_pick_req = {bus.dma_req, bus.cpu_req};
      ST_CPU_BUSY: if (bus.mem_ready) w_pick_req = {bus.dma_req, 1'b0};
      ST_DMA_BUSY: if (bus.mem_ready) w_pick_req = {1'b0, bus.cpu_req};
      default:     w_pick_req = 2'b00;
    endcase
  end

  rr_pick2 u_pick (
    .i_req        (w_pick_req),
    .i_last_owner (r_last_owner),
    .o_gnt_idx    (w_gnt_idx),
    .o_any        (w_any)
  );

  always_comb begin
    w_next        = r_state;
    bus.cpu_stall = bus.cpu_req & ~((r_state == ST_CPU_BUSY) & w_end);
    bus.dma_gnt   = (r_state == ST_DMA_BUSY) & w_end & ~reset;
    bus.err       = w_timeout & ~reset;
    bus.dma_rdata = '0;
    if (bus.dma_gnt) bus.dma_rdata = w_timeout ? ABORT_DATA : bus.mem_rdata;
    if (w_any)      w_next = w_gnt_idx ? ST_DMA_BUSY : ST_CPU_BUSY;
    else if (w_end) w_next = ST_IDLE;
    if (r_state != ST_IDLE && r_state != ST_CPU_BUSY && r_state != ST_DMA_BUSY)
      w_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_owner <= 1'b1;
      r_cnt        <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_be     <= '0;
      r_mem_wdata  <= '0;
      r_cpu_rdata  <= '0;
    end else begin
      r_state <= w_next;
      if (w_end) r_last_owner <= (r_state == ST_DMA_BUSY);

      if (w_any) begin
        r_cnt    <= '0;
        r_mem_en <= 1'b1;
        if (w_gnt_idx) begin
          r_mem_we    <= bus.dma_we;
          r_mem_addr  <= word_addr(bus.dma_addr);
          r_mem_be    <= bus.dma_be;
          r_mem_wdata <= bus.dma_wdata;
        end else begin
          r_mem_we    <= bus.cpu_we;
          r_mem_addr  <= word_addr(bus.cpu_addr);
          r_mem_be    <= bus.cpu_be;
          r_mem_wdata <= bus.cpu_wdata;
        end
      end else if (w_end) begin
        r_cnt    <= '0;
        r_mem_en <= 1'b0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (r_state == ST_CPU_BUSY) begin
        if (w_timeout)                      r_cpu_rdata <= ABORT_DATA;
        else if (bus.mem_ready & ~r_mem_we) r_cpu_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.cpu_rdata = r_cpu_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: arbitration, back-to-back, hold, timeout, reset.
module tb_dm_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   early = 0;

  always #5 clk = ~clk;

  dm_arbiter_if bus ();

  dm_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr;
    bus.cpu_be = be; bus.cpu_wdata = wdata;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
    bus.dma_req = req; bus.dma_we = we; bus.dma_addr = addr;
    bus.dma_be = be; bus.dma_wdata = wdata;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    set_cpu(0, 0, 0, 0, 0);
    set_dma(0, 0, 0, 0, 0);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    do_reset();

    // Reset state
    #1;
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_be", bus.mem_be, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_dma_gnt", bus.dma_gnt, 0);
    chk("rst_dma_rdata", bus.dma_rdata, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_stall", bus.cpu_stall, 0);

    // 1: CPU load alone
    set_cpu(1, 0, 32'h0000_0013, 4'hF, 0);
    #1 chk("t1_stall_c0", bus.cpu_stall, 1);
    tick();
    #1 chk("t1_mem_en", bus.mem_en, 1);
    chk("t1_mem_addr", bus.mem_addr, 32'h0000_0010);
    chk("t1_mem_we", bus.mem_we, 0);
    chk("t1_stall_c1", bus.cpu_stall, 1);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234_5678;
    #1 chk("t1_stall_done", bus.cpu_stall, 0);
    chk("t1_no_dma_gnt", bus.dma_gnt, 0);
    tick();
    set_cpu(0, 0, 0, 0, 0);
    bus.mem_ready = 1'b0;
    #1 chk("t1_cpu_rdata", bus.cpu_rdata, 32'h1234_5678);
    chk("t1_mem_en_off", bus.mem_en, 0);

    // 2: simultaneous requests after reset
    do_reset();
    set_cpu(1, 1, 32'h0000_0100, 4'hF, 32'h1111_1111);
    set_dma(1, 0, 32'h0000_0204, 4'hF, 0);
    #1 chk("t2_stall_c0", bus.cpu_stall, 1);
    chk("t2_gnt_c0", bus.dma_gnt, 0);
    tick();
    #1 chk("t2_cpu_addr", bus.mem_addr, 32'h0000_0100);
    chk("t2_cpu_we", bus.mem_we, 1);
    chk("t2_cpu_wdata", bus.mem_wdata, 32'h1111_1111);
    chk("t2_en_cpu", bus.mem_en, 1);
    bus.mem_ready = 1'b1;
    #1 chk("t2_stall_done", bus.cpu_stall, 0);
    chk("t2_gnt_during_cpu", bus.dma_gnt, 0);
    tick();
    set_cpu(0, 0, 0, 0, 0);
    bus.mem_ready = 1'b0;
    #1 chk("t2_en_dma", bus.mem_en, 1);
    chk("t2_dma_addr", bus.mem_addr, 32'h0000_0204);
    chk("t2_dma_we", bus.mem_we, 0);
    chk("t2_store_keeps_rdata", bus.cpu_rdata, 0);
    chk("t2_gnt_wait", bus.dma_gnt, 0);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    #1 chk("t2_gnt", bus.dma_gnt, 1);
    chk("t2_dma_rdata", bus.dma_rdata, 32'hCAFE_F00D);
    tick();
    set_dma(0, 0, 0, 0, 0);
    bus.mem_ready = 1'b0;
    #1 chk("t2_gnt_once", bus.dma_gnt, 0);
    chk("t2_en_off", bus.mem_en, 0);

    // 3: continuous requests alternate CPU/DMA
    set_cpu(1, 0, 32'h0000_1000, 4'hF, 0);
    set_dma(1, 0, 32'h0000_2000, 4'hF, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) bus.cpu_req = 1'b0;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h100 + i;
      #1;
      chk($sformatf("t3_addr_%0d", i), bus.mem_addr, (i % 2 == 0) ? 32'h1000 : 32'h2000);
      chk($sformatf("t3_gnt_%0d", i), bus.dma_gnt, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("t3_en_%0d", i), bus.mem_en, 1);
      chk($sformatf("t3_stall_%0d", i), bus.cpu_stall, (i % 2 == 1 && i != 5) ? 1 : 0);
    end
    tick();
    set_dma(0, 0, 0, 0, 0);
    bus.mem_ready = 1'b0;
    #1 chk("t3_en_off", bus.mem_en, 0);
    chk("t3_cpu_rdata", bus.cpu_rdata, 32'h104);

    // 4: CPU store held stable, then DMA write with partial byte enable
    set_cpu(1, 1, 32'h0000_0302, 4'b0011, 32'h5566_7788);
    set_dma(1, 1, 32'h0000_0040, 4'b0100, 32'hAABB_CCDD);
    for (int k = 0; k < 2; k++) begin
      tick();
      #1;
      chk($sformatf("t4_cpu_addr_%0d", k), bus.mem_addr, 32'h0000_0300);
      chk($sformatf("t4_cpu_be_%0d", k), bus.mem_be, 4'b0011);
      chk($sformatf("t4_cpu_wdata_%0d", k), bus.mem_wdata, 32'h5566_7788);
      chk($sformatf("t4_cpu_we_%0d", k), bus.mem_we, 1);
    end
    bus.mem_ready = 1'b1;
    #1 chk("t4_stall_done", bus.cpu_stall, 0);
    tick();
    set_cpu(0, 0, 0, 0, 0);
    bus.mem_ready = 1'b0;
    #1 chk("t4_dma_addr", bus.mem_addr, 32'h0000_0040);
    chk("t4_dma_we", bus.mem_we, 1);
    chk("t4_dma_be", bus.mem_be, 4'b0100);
    chk("t4_dma_wdata", bus.mem_wdata, 32'hAABB_CCDD);
    chk("t4_cpu_rdata_kept", bus.cpu_rdata, 32'h104);
    bus.mem_ready = 1'b1;
    #1 chk("t4_gnt", bus.dma_gnt, 1);
    tick();
    set_dma(0, 0, 0, 0, 0);
    bus.mem_ready = 1'b0;

    // 5: watchdog abort of a CPU load
    set_cpu(1, 0, 32'h0000_0500, 4'hF, 0);
    tick();
    for (int k = 0; k < 16; k++) begin
      #1;
      if (bus.err !== 1'b0) early++;
      tick();
    end
    chk("t5_no_early_err", early, 0);
    #1 chk("t5_err", bus.err, 1);
    chk("t5_stall_drop", bus.cpu_stall, 0);
    tick();
    set_cpu(0, 0, 0, 0, 0);
    #1 chk("t5_err_pulse", bus.err, 0);
    chk("t5_rdata_abort", bus.cpu_rdata, 32'hDEAD_BEEF);
    chk("t5_en_off", bus.mem_en, 0);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0BAD_0BAD;
    tick();
    bus.mem_ready = 1'b0;
    #1 chk("t5_idle_ignores_ready", bus.cpu_rdata, 32'hDEAD_BEEF);
    chk("t5_idle_no_gnt", bus.dma_gnt, 0);

    // 6: reset during DMA_BUSY, then a zero-byte-enable CPU load
    set_dma(1, 0, 32'h0000_0600, 4'hF, 0);
    tick();
    #1 chk("t6_dma_busy_en", bus.mem_en, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_dma(0, 0, 0, 0, 0);
    bus.mem_ready = 1'b1;
    #1 chk("t6_en_off", bus.mem_en, 0);
    chk("t6_no_gnt", bus.dma_gnt, 0);
    chk("t6_no_err", bus.err, 0);
    chk("t6_addr_rst", bus.mem_addr, 0);
    chk("t6_rdata_rst", bus.cpu_rdata, 0);
    bus.mem_ready = 1'b0;
    set_cpu(1, 0, 32'h0000_0704, 4'b0000, 0);
    #1 chk("t6_stall", bus.cpu_stall, 1);
    tick();
    #1 chk("t6_addr", bus.mem_addr, 32'h0000_0704);
    chk("t6_be_zero", bus.mem_be, 4'b0000);
    chk("t6_en", bus.mem_en, 1);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h7654_3210;
    #1 chk("t6_stall_done", bus.cpu_stall, 0);
    tick();
    set_cpu(0, 0, 0, 0, 0);
    bus.mem_ready = 1'b0;
    #1 chk("t6_cpu_rdata", bus.cpu_rdata, 32'h7654_3210);
    chk("t6_en_off_end", bus.mem_en, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
